// File: rtl/delay_cal_pkg.sv
// Shared types and default sizes for the delay-calibration burst generator.
package delay_cal_pkg;

  localparam int unsigned W_DEF     = 256;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    PULSE,
    GAP,
    DONE
  } dc_state_t;

endpackage

// File: rtl/delay_cal_edge.sv
// Registered rising-edge detector: rise is high for the cycle in which in first reads 1.
module delay_cal_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_q <= 1'b0;
    else      in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/delay_cal_burst.sv
// Trigger-launched calibration burst: start delay, then n pulses of a latched word
// separated by zero gaps, with a one-cycle done strobe at the end.
module delay_cal_burst
  import delay_cal_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             abort,
  input  logic [W-1:0]     static_word,
  input  logic [CNT_W-1:0] delay_cyc,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] n_pulses,
  output logic [W-1:0]     word_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx
);

  dc_state_t        state, state_d;
  logic             rise, load;
  logic [W-1:0]     word_q, word_out_d;
  logic [CNT_W-1:0] len_q, gap_q, n_q;
  logic [CNT_W-1:0] cnt, cnt_d, rem, rem_d, idx_d;
  logic [CNT_W-1:0] len_m1_in, len_m1_sh, idx_inc;

  delay_cal_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (trig),
    .rise (rise)
  );

  assign len_m1_in = (pulse_len == '0) ? '0 : pulse_len - 1'b1;
  assign len_m1_sh = (len_q == '0) ? '0 : len_q - 1'b1;
  assign idx_inc   = (pulse_idx == '1) ? pulse_idx : pulse_idx + 1'b1;

  // cnt holds remaining cycles-1 of the current phase; rem holds pulses still to start.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rem_d   = rem;
    idx_d   = pulse_idx;
    load    = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (rise) begin
          load  = 1'b1;
          idx_d = '0;
          rem_d = (n_pulses == '0) ? '0 : n_pulses - 1'b1;
          if (delay_cyc != '0) begin
            state_d = DELAY;
            cnt_d   = delay_cyc - 1'b1;
          end else if (n_pulses == '0) begin
            state_d = DONE;
          end else begin
            state_d = PULSE;
            cnt_d   = len_m1_in;
          end
        end
        DELAY: begin
          if (cnt != '0) begin
            cnt_d = cnt - 1'b1;
          end else if (n_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = PULSE;
            cnt_d   = len_m1_sh;
          end
        end
        PULSE: begin
          if (cnt != '0) begin
            cnt_d = cnt - 1'b1;
          end else if (rem == '0) begin
            state_d = DONE;
          end else if (gap_q != '0) begin
            state_d = GAP;
            cnt_d   = gap_q - 1'b1;
          end else begin
            cnt_d = len_m1_sh;
            rem_d = rem - 1'b1;
            idx_d = idx_inc;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt_d = cnt - 1'b1;
          end else begin
            state_d = PULSE;
            cnt_d   = len_m1_sh;
            rem_d   = rem - 1'b1;
            idx_d   = idx_inc;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    word_out_d = (state_d == PULSE) ? (load ? static_word : word_q) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      pulse_idx <= '0;
      word_q    <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      n_q       <= '0;
      word_out  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rem       <= rem_d;
      pulse_idx <= idx_d;
      word_out  <= word_out_d;
      if (load) begin
        word_q <= static_word;
        len_q  <= pulse_len;
        gap_q  <= gap_len;
        n_q    <= n_pulses;
      end
    end
  end

  assign busy = state inside {DELAY, PULSE, GAP};
  assign done = (state == DONE);

endmodule

// File: tb/tb_delay_cal_burst.sv
// Self-checking bench for delay_cal_burst: table vectors, directed corner sequences
// and randomized bursts against a per-cycle timeline model.
module tb_delay_cal_burst;

  localparam int unsigned W  = 256;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst, trig, abort;
  logic [W-1:0]  static_word, word_out;
  logic [CW-1:0] delay_cyc, pulse_len, gap_len, n_pulses, pulse_idx;
  logic          busy, done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    int unsigned  delay, len, gap, n;
    logic [W-1:0] word;
    int unsigned  exp_busy, exp_words;
  } vec_t;

  typedef struct {
    bit          w, busy, done;
    int unsigned idx;
  } exp_t;

  exp_t eq[$];

  always #5 clk = ~clk;

  delay_cal_burst #(.W(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .abort       (abort),
    .static_word (static_word),
    .delay_cyc   (delay_cyc),
    .pulse_len   (pulse_len),
    .gap_len     (gap_len),
    .n_pulses    (n_pulses),
    .word_out    (word_out),
    .busy        (busy),
    .done        (done),
    .pulse_idx   (pulse_idx)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int unsigned i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Timeline of what each cycle after the launch edge must look like.
  task automatic build(input vec_t c);
    int unsigned l;
    l = (c.len == 0) ? 1 : c.len;
    eq.delete();
    for (int unsigned d = 0; d < c.delay; d++) eq.push_back('{1'b0, 1'b1, 1'b0, 0});
    for (int unsigned p = 0; p < c.n; p++) begin
      for (int unsigned k = 0; k < l; k++) eq.push_back('{1'b1, 1'b1, 1'b0, p});
      if (p + 1 < c.n)
        for (int unsigned g = 0; g < c.gap; g++) eq.push_back('{1'b0, 1'b1, 1'b0, p});
    end
    eq.push_back('{1'b0, 1'b0, 1'b1, (c.n == 0) ? 0 : c.n - 1});
  endtask

  task automatic apply_cfg(input vec_t c);
    static_word = c.word;
    delay_cyc   = CW'(c.delay);
    pulse_len   = CW'(c.len);
    gap_len     = CW'(c.gap);
    n_pulses    = CW'(c.n);
  endtask

  task automatic scramble_cfg();
    static_word = rand_word();
    delay_cyc   = CW'($urandom_range(0, 7));
    pulse_len   = CW'($urandom_range(0, 7));
    gap_len     = CW'($urandom_range(0, 7));
    n_pulses    = CW'($urandom_range(0, 7));
  endtask

  task automatic run_burst(input vec_t c, input bit mutate, input bit hold,
                           output int unsigned busy_cnt, output int unsigned word_cnt);
    exp_t e;
    apply_cfg(c);
    trig = 1'b0;
    @(negedge clk);
    trig = 1'b1;
    build(c);
    busy_cnt = 0;
    word_cnt = 0;
    for (int i = 0; i < eq.size() + 3; i++) begin
      @(negedge clk);
      if (i < eq.size()) e = eq[i];
      else e = '{1'b0, 1'b0, 1'b0, eq[eq.size()-1].idx};
      chk("word_out", word_out, e.w ? c.word : '0);
      chk("busy", W'(busy), W'(e.busy));
      chk("done", W'(done), W'(e.done));
      chk("pulse_idx", W'(pulse_idx), W'(e.idx));
      busy_cnt += busy;
      if (word_out != '0) word_cnt++;
      if (mutate) scramble_cfg();
      if (!hold) trig = (mutate && i + 1 < eq.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  vec_t        vecs[5];
  vec_t        v;
  int unsigned bc, wc;

  initial begin
    vecs[0] = '{0, 1, 0, 1, {32{8'hA5}}, 1, 1};
    vecs[1] = '{3, 2, 1, 3, rand_word() | 1, 11, 6};
    vecs[2] = '{0, 2, 0, 2, rand_word() | 1, 4, 4};
    vecs[3] = '{2, 1, 0, 0, rand_word() | 1, 2, 0};
    vecs[4] = '{1, 0, 2, 2, rand_word() | 1, 5, 2};

    rst = 1'b0; trig = 1'b0; abort = 1'b0;
    apply_cfg(vecs[0]);
    repeat (2) @(negedge clk);
    chk("reset word_out", word_out, '0);
    chk("reset busy", W'(busy), '0);
    chk("reset done", W'(done), '0);
    chk("reset pulse_idx", W'(pulse_idx), '0);
    rst = 1'b1;
    @(negedge clk);

    // Table vectors; the first holds trig high throughout to show no relaunch.
    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i], 1'b0, i == 0, bc, wc);
      chk("busy_cycles", W'(bc), W'(vecs[i].exp_busy));
      chk("word_cycles", W'(wc), W'(vecs[i].exp_words));
      trig = 1'b0;
    end

    // abort together with a rise in IDLE: no launch
    apply_cfg(vecs[0]);
    @(negedge clk);
    trig = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_rise busy", W'(busy), '0);
    chk("abort_rise word", word_out, '0);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_rise no launch", W'(busy), '0);
    trig = 1'b0;

    // abort during the second pulse of a 4-pulse burst
    v = '{0, 3, 1, 4, rand_word() | 1, 0, 0};
    apply_cfg(v);
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort pre idx", W'(pulse_idx), 1);
    chk("abort pre word", word_out, v.word);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort word", word_out, '0);
    chk("abort busy", W'(busy), '0);
    chk("abort done", W'(done), '0);
    bc = 0;
    repeat (6) begin
      @(negedge clk);
      bc += done + busy;
    end
    chk("abort quiet", W'(bc), '0);
    v.exp_busy = 3 * 4 + 3;
    run_burst(v, 1'b0, 1'b0, bc, wc);
    chk("post_abort busy_cycles", W'(bc), W'(v.exp_busy));

    // async reset mid-pulse, config change and retrigger while busy
    v = '{1, 4, 0, 2, rand_word() | 1, 0, 0};
    apply_cfg(v);
    trig = 1'b0;
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst pulse0 word", word_out, v.word);
    scramble_cfg();
    trig = 1'b0;
    @(negedge clk);
    chk("cfg change ignored", word_out, v.word);
    trig = 1'b1;
    @(negedge clk);
    chk("retrig ignored word", word_out, v.word);
    chk("retrig ignored idx", W'(pulse_idx), '0);
    #2 rst = 1'b0;
    #1;
    chk("async rst word", word_out, '0);
    chk("async rst busy", W'(busy), '0);
    trig = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("after rst idle", W'(busy), '0);
    run_burst(v, 1'b0, 1'b0, bc, wc);
    chk("post_rst words", W'(wc), 8);

    // randomized bursts with mid-burst config scrambling and trig noise
    for (int r = 0; r < 40; r++) begin
      v = '{$urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 4), rand_word() | 1, 0, 0};
      run_burst(v, 1'b1, 1'b0, bc, wc);
      trig = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
